div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
//  Produces {remainder, quotient}; EX forwards it down the pipe, and the HI/LO register
//  file captures remainder->HI and quotient->LO at write-back.
//  EX stalls the pipeline while a division is in progress (ready_o low after start).
// PARAMETERS
//  DATA_W   32   operand width; result_o is 2*DATA_W; iteration count = DATA_W
// PORTS
//  clk           in   1         clock, all state updates on posedge
//  rst           in   1         synchronous reset, active-low (0 = reset)
//  signed_div_i  in   1         1 = DIV (signed), 0 = DIVU
//  opdata1_i     in   DATA_W    dividend
//  opdata2_i     in   DATA_W    divisor
//  start_i       in   1         request; held high by EX until ready_o seen
//  annul_i       in   1         cancel in-flight division (flush/exception)
//  result_o      out  2*DATA_W  [2W-1:W] remainder (HI), [W-1:0] quotient (LO)
//  ready_o       out  1         result_o valid this cycle
// BEHAVIOUR
//  Reset: state=FREE, result_o=0, ready_o=0, counter=0.
//  Reset takes priority in every state (a division in progress is discarded).
//  States: FREE, BYZERO, ON, END (2-bit encoding)
//   FREE:   start_i=1 & annul_i=0: divisor==0 -> BYZERO; else -> ON.
//           On entering ON, latch |a|,|b| (abs taken only if signed_div_i), clear counter.
//           ready_o=0, result_o=0.
//   BYZERO: -> END next cycle with quotient=0, remainder=0.
//   ON:     annul_i=1 -> FREE, ready_o=0, result discarded.
//           Otherwise each cycle does one step: shift {rem,quo} left 1, trial-subtract |b|;
//           if no borrow, keep the difference and set quo[0]=1.
//           After DATA_W steps -> END.
//   END:    Sign fix-up: if signed and sign(a)^sign(b), negate quotient.
//           If signed and sign(a), negate remainder.
//           Then ready_o=1 and result_o holds.
//           Stay in END while start_i=1.
//           start_i=0 -> FREE; ready_o and result_o clear to 0 on that transition.
//  Operands and signed_div_i are sampled only on FREE->ON; later changes are ignored.
//  Latency: start sampled at edge 0; ready_o first high after edge DATA_W+1 (nonzero
//   divisor), after edge 2 (zero divisor).
//  Sign fix-up may be done at the END entry edge or pipelined.
//   Required: exactly one END entry, and result valid whenever ready_o=1.
//  Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000 (wraps), remainder 0.
//  annul_i in FREE/BYZERO/END: no effect except in ON; in FREE it blocks the start.
//  No back-to-back: a new start needs one FREE cycle (start_i low) after END.
// STRUCTURE
//  Shared defines file: state codes (DivFree, DivByZero, DivOn, DivEnd),
//   DivStart/DivStop, DivResultReady/NotReady, DivWidth (= DATA_W).
//  Single module: the step datapath is 33-bit subtract + shift, kept inline.
//  No sub-module.
// TESTING
//  1. DIVU 100/7: ready_o high 33 cycles after start -> result_o = {32'd2, 32'd14}.
//  2. DIV -7/2 signed: quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
//     DIV 7/-2: quotient -3, remainder +1.
//  3. Divisor 0: ready_o high after 2 cycles, result_o = 0.
//     Dropping start_i returns to FREE with ready_o=0.
//  4. Signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000}.
//     Same operands with DIVU -> {0x80000000, 0}.
//  5. annul_i pulsed at step 10 -> FREE, ready_o never asserts.
//     Then a fresh 9/3 completes with result_o = {0, 3}.
//  6. rst low mid-ON (step 20) -> next cycle state FREE, ready_o=0, result_o=0.
//     Hold start_i high 5 cycles in END -> ready_o and result stable throughout.

Source files
------------

// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
// Purpose : shared definitions for the multi-cycle DIV/DIVU unit: operand
//           width, FSM state codes and start/ready level names.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package div_unit_pkg;

  localparam int DivWidth = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_if
// Purpose : request/result bundle between the EX stage (master) and the
//           divider (slave).
// Signals : signed_div_i  1 = DIV, 0 = DIVU
//           opdata1_i     dividend
//           opdata2_i     divisor
//           start_i       request, held by EX until ready_o
//           annul_i       cancel an in-flight division
//           result_o      {remainder, quotient}
//           ready_o       result_o valid
// ---------------------------------------------------------------------------
interface div_unit_if #(parameter int DATA_W = 32);

  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  start_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Purpose : radix-2 restoring divider for DIV/DIVU. One quotient bit per
//           cycle on magnitudes; signs are applied once the iterations are
//           done. Result is {remainder (HI), quotient (LO)}.
// Ports   : clk     clock, all state on posedge
//           rst     synchronous reset, active-low
//           div_if  slave side of div_unit_if (operands, start/annul,
//                   result/ready)
//
// state     | meaning
// ----------+---------------------------------------------------------------
// DivFree   | idle, waiting for start_i (annul_i blocks a start)
// DivByZero | divisor was zero, result forced to 0
// DivOn     | iterating, one shift/trial-subtract per cycle
// DivEnd    | sign fix-up applied, ready_o high while start_i held
// ---------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DivWidth
) (
  input  logic        clk,
  input  logic        rst,
  div_unit_if.slave   div_if
);

  localparam int CntW = $clog2(DATA_W);

  div_state_e            r_state,   w_state_nxt;
  logic [CntW-1:0]       r_cnt,     w_cnt_nxt;
  logic [DATA_W-1:0]     r_rem,     w_rem_nxt;
  logic [DATA_W-1:0]     r_quo,     w_quo_nxt;
  logic [DATA_W-1:0]     r_divisor, w_divisor_nxt;
  logic                  r_neg_q,   w_neg_q_nxt;
  logic                  r_neg_r,   w_neg_r_nxt;
  logic [2*DATA_W-1:0]   r_result,  w_result_nxt;
  logic                  r_ready,   w_ready_nxt;

  logic [DATA_W-1:0]     w_abs_a;
  logic [DATA_W-1:0]     w_abs_b;
  logic [DATA_W:0]       w_trial;
  logic                  w_borrow;
  logic [DATA_W-1:0]     w_quo_fix;
  logic [DATA_W-1:0]     w_rem_fix;

  // Magnitudes only matter for DIV; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  assign w_abs_a = (div_if.signed_div_i && div_if.opdata1_i[DATA_W-1])
                   ? -div_if.opdata1_i : div_if.opdata1_i;
  assign w_abs_b = (div_if.signed_div_i && div_if.opdata2_i[DATA_W-1])
                   ? -div_if.opdata2_i : div_if.opdata2_i;

  // Partial remainder shifted left with the next dividend bit, minus divisor.
  // The extra top bit is the borrow: set means the trial went negative.
  assign w_trial  = {r_rem, r_quo[DATA_W-1]} - {1'b0, r_divisor};
  assign w_borrow = w_trial[DATA_W];

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= DivFree;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rem     <= w_rem_nxt;
      r_quo     <= w_quo_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rem_nxt     = r_rem;
    w_quo_nxt     = r_quo;
    w_divisor_nxt = r_divisor;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_result_nxt  = '0;
    w_ready_nxt   = DivResultNotReady;

    unique case (r_state)
      DivFree: begin
        if (div_if.start_i == DivStart && !div_if.annul_i) begin
          w_cnt_nxt = '0;
          w_rem_nxt = '0;
          if (div_if.opdata2_i == '0) begin
            w_state_nxt = DivByZero;
            w_quo_nxt   = '0;
            w_neg_q_nxt = 1'b0;
            w_neg_r_nxt = 1'b0;
          end else begin
            w_state_nxt   = DivOn;
            w_quo_nxt     = w_abs_a;
            w_divisor_nxt = w_abs_b;
            w_neg_q_nxt   = div_if.signed_div_i &
                            (div_if.opdata1_i[DATA_W-1] ^ div_if.opdata2_i[DATA_W-1]);
            w_neg_r_nxt   = div_if.signed_div_i & div_if.opdata1_i[DATA_W-1];
          end
        end
      end

      DivByZero: begin
        w_state_nxt = DivEnd;
      end

      DivOn: begin
        if (div_if.annul_i) begin
          w_state_nxt = DivFree;
        end else begin
          w_rem_nxt = w_borrow ? {r_rem[DATA_W-2:0], r_quo[DATA_W-1]}
                               : w_trial[DATA_W-1:0];
          w_quo_nxt = {r_quo[DATA_W-2:0], ~w_borrow};
          w_cnt_nxt = r_cnt + CntW'(1);
          if (r_cnt == CntW'(DATA_W - 1)) begin
            w_state_nxt = DivEnd;
          end
        end
      end

      DivEnd: begin
        if (div_if.start_i == DivStop) begin
          w_state_nxt = DivFree;
        end else begin
          // Recomputed from held magnitudes each cycle, so it stays stable.
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = DivResultReady;
        end
      end

      default: w_state_nxt = DivFree;
    endcase
  end

  assign div_if.result_o = r_result;
  assign div_if.ready_o  = r_ready;

endmodule
